axi_mem_responder: RTL and testbench

AXI4 slave memory model: the responder end of the system's `m_axi` master port. It terminates the AXI4 write and read channels on an internal dual-port byte-enabled RAM, supports INCR/FIXED bursts, and serves as the DDR stand-in in simulation and as on-chip backing memory in FPGA builds without DDR. Write and read paths are independent FSMs sharing only the memory array.

---
 rtl/axi_mem_responder.sv | 193 +++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model on a byte-enabled dual-port RAM with independent write and read FSMs.
// Optional feature macro: AXI_MEM_RANGE_CHECK_EN (SLVERR for start addresses beyond the backed RAM).
module axi_mem_responder #(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int MEM_ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AXI_ID_W-1:0]     s_axi_awid,
  input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic [1:0]              s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [AXI_ID_W-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [AXI_ID_W-1:0]     s_axi_arid,
  input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic [1:0]              s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [AXI_ID_W-1:0]     s_axi_rid,
  output logic [AXI_DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int WIDX_W = MEM_ADDR_W - LSB;
  localparam int DEPTH  = 2 ** WIDX_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [AXI_DATA_W-1:0] mem [DEPTH];

  w_state_t              w_state, w_next;
  logic [AXI_ID_W-1:0]   w_id;
  logic [WIDX_W-1:0]     w_idx;
  logic [7:0]            w_len, w_cnt;
  logic                  w_fixed, w_err, w_oob;
  r_state_t              r_state, r_next;
  logic [AXI_ID_W-1:0]   r_id;
  logic [WIDX_W-1:0]     r_idx;
  logic [7:0]            r_len, r_cnt;
  logic                  r_fixed, r_oob;
  logic [AXI_DATA_W-1:0] r_data;
  logic                  aw_oob, ar_oob;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, w_final, r_final;

`ifdef AXI_MEM_RANGE_CHECK_EN
  assign aw_oob = |s_axi_awaddr[AXI_ADDR_W-1:MEM_ADDR_W];
  assign ar_oob = |s_axi_araddr[AXI_ADDR_W-1:MEM_ADDR_W];
`else
  assign aw_oob = 1'b0;
  assign ar_oob = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                       s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                       s_axi_awaddr[AXI_ADDR_W-1:MEM_ADDR_W], s_axi_araddr[AXI_ADDR_W-1:MEM_ADDR_W],
                       s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign b_hs    = s_axi_bvalid && s_axi_bready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign r_hs    = s_axi_rvalid && s_axi_rready;
  assign w_final = (w_cnt == w_len);
  assign r_final = (r_cnt == r_len);

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_final) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Ready/valid are forced low while reset is held so every output reads 0 during reset.
  always_comb begin
    s_axi_awready = !rst && (w_state == W_IDLE);
    s_axi_wready  = !rst && (w_state == W_DATA);
    s_axi_bvalid  = !rst && (w_state == W_RESP);
    s_axi_bresp   = (s_axi_bvalid && (w_err || w_oob)) ? 2'b10 : 2'b00;
    s_axi_bid     = w_id;
  end

  // The burst ends on the beat count alone; a misplaced wlast only taints the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_id <= '0; w_idx <= '0; w_len <= '0; w_cnt <= '0;
      w_fixed <= 1'b0; w_err <= 1'b0; w_oob <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= s_axi_awid;
      w_idx   <= s_axi_awaddr[MEM_ADDR_W-1:LSB];
      w_len   <= s_axi_awlen;
      w_fixed <= (s_axi_awburst == 2'b00);
      w_cnt   <= '0;
      w_err   <= 1'b0;
      w_oob   <= aw_oob;
    end else if (w_hs) begin
      w_cnt <= w_cnt + 8'd1;
      if (!w_fixed) w_idx <= w_idx + WIDX_W'(1);
      if (s_axi_wlast != w_final) w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_oob) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_FETCH;
      R_FETCH: r_next = R_DATA;
      R_DATA:  if (r_hs) r_next = r_final ? R_IDLE : R_FETCH;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = !rst && (r_state == R_IDLE);
    s_axi_rvalid  = !rst && (r_state == R_DATA);
    s_axi_rlast   = s_axi_rvalid && r_final;
    s_axi_rresp   = (s_axi_rvalid && r_oob) ? 2'b10 : 2'b00;
    s_axi_rdata   = r_data;
    s_axi_rid     = r_id;
  end

  // The fetch register samples the array before same-cycle writes land, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id <= '0; r_idx <= '0; r_len <= '0; r_cnt <= '0;
      r_fixed <= 1'b0; r_oob <= 1'b0; r_data <= '0;
    end else begin
      if (ar_hs) begin
        r_id    <= s_axi_arid;
        r_idx   <= s_axi_araddr[MEM_ADDR_W-1:LSB];
        r_len   <= s_axi_arlen;
        r_fixed <= (s_axi_arburst == 2'b00);
        r_cnt   <= '0;
        r_oob   <= ar_oob;
      end else if (r_hs) begin
        r_cnt <= r_cnt + 8'd1;
        if (!r_fixed) r_idx <= r_idx + WIDX_W'(1);
      end
      if (r_state == R_FETCH) r_data <= r_oob ? '0 : mem[r_idx];
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder with a word-level memory model and response scoreboards.
module tb_axi_mem_responder;

  localparam int LIM = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;

  typedef struct { logic [31:0] data; logic last; logic [1:0] resp; logic id; } rbeat_t;
  typedef struct { logic id; logic [1:0] resp; } bresp_t;

  rbeat_t      r_q[$];
  bresp_t      b_q[$];
  logic [31:0] model [int];
  logic [31:0] wbuf [16];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(3'd2),
    .s_axi_awburst(awburst), .s_axi_awlock(2'b00), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awqos(4'd0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(3'd2),
    .s_axi_arburst(arburst), .s_axi_arlock(2'b00), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arqos(4'd0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_oob(input logic [31:0] addr);
`ifdef AXI_MEM_RANGE_CHECK_EN
    return |addr[31:16];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_idx(input logic [31:0] addr, input logic [1:0] burst, input int beat);
    return (int'(addr[15:2]) + ((burst == 2'b00) ? 0 : beat)) % 16384;
  endfunction

  // early_last >= 0 puts wlast on that beat instead of the final one.
  task automatic do_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] strb,
                          input int early_last, input int hold);
    bit     mismatch = 0;
    bit     oob = addr_oob(addr);
    bresp_t exp_b, got_b;
    int     t;
    logic   wl;
    for (int i = 0; i <= int'(len); i++) begin
      wl = (early_last >= 0) ? (i == early_last) : (i == int'(len));
      if (wl != (i == int'(len))) mismatch = 1;
      if (!oob) begin
        int idx = word_idx(addr, burst, i);
        logic [31:0] cur = model.exists(idx) ? model[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) cur[b*8 +: 8] = wbuf[i][b*8 +: 8];
        model[idx] = cur;
      end
    end
    exp_b.id = id;
    exp_b.resp = (mismatch || oob) ? 2'b10 : 2'b00;
    b_q.push_back(exp_b);

    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < LIM) begin @(negedge clk); t++; end
    check("aw_timeout", t >= LIM, 0);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb;
      wlast = (early_last >= 0) ? (i == early_last) : (i == int'(len));
      t = 0;
      while (!wready && t < LIM) begin @(negedge clk); t++; end
      check("w_timeout", t >= LIM, 0);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("bvalid_after_last", bvalid, 1);
    for (int h = 0; h < hold; h++) begin
      check("b_hold_valid", bvalid, 1);
      check("b_hold_resp", bresp, exp_b.resp);
      check("b_hold_awready", awready, 0);
      @(negedge clk);
    end
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < LIM) begin @(negedge clk); t++; end
    check("b_timeout", t >= LIM, 0);
    got_b = b_q.pop_front();
    check("bid", bid, got_b.id);
    check("bresp", bresp, got_b.resp);
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_drop", bvalid, 0);
  endtask

  task automatic do_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int hold);
    bit     oob = addr_oob(addr);
    rbeat_t e;
    int     t;
    for (int i = 0; i <= int'(len); i++) begin
      int idx = word_idx(addr, burst, i);
      e.data = oob ? 32'h0 : (model.exists(idx) ? model[idx] : 32'h0);
      e.last = (i == int'(len));
      e.resp = oob ? 2'b10 : 2'b00;
      e.id   = id;
      r_q.push_back(e);
    end
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    rready = (hold == 0);
    t = 0;
    while (!arready && t < LIM) begin @(negedge clk); t++; end
    check("ar_timeout", t >= LIM, 0);
    @(negedge clk);
    arvalid = 1'b0;
    check("r_latency_c1", rvalid, 0);
    @(negedge clk);
    check("r_latency_c2", rvalid, 1);
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!rvalid && t < LIM) begin @(negedge clk); t++; end
      check("r_timeout", t >= LIM, 0);
      if (i == 0 && hold > 0) begin
        for (int h = 0; h < hold; h++) begin
          check("r_hold_valid", rvalid, 1);
          check("r_hold_data", rdata, r_q[0].data);
          check("r_hold_arready", arready, 0);
          @(negedge clk);
        end
        rready = 1'b1;
      end
      e = r_q.pop_front();
      check("rdata", rdata, e.data);
      check("rlast", rlast, e.last);
      check("rresp", rresp, e.resp);
      check("rid", rid, e.id);
      @(negedge clk);
      check("r_gap", rvalid, 0);
    end
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_outputs", {bresp, rresp, rlast, bid, rid}, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", awready, 1);
    check("post_rst_arready", arready, 1);

    $display("[TB] single write/read");
    wbuf[0] = 32'hDEADBEEF;
    do_write(1'b0, 32'h100, 8'd0, 2'b01, 4'hF, -1, 0);
    do_read(1'b0, 32'h100, 8'd0, 2'b01, 0);

    $display("[TB] INCR burst of 4");
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(1'b1, 32'h200, 8'd3, 2'b01, 4'hF, -1, 0);
    do_read(1'b1, 32'h200, 8'd3, 2'b01, 0);

    $display("[TB] partial strobe");
    wbuf[0] = 32'h11223344;
    do_write(1'b0, 32'h300, 8'd0, 2'b01, 4'hF, -1, 0);
    wbuf[0] = 32'hFFFFFFFF;
    do_write(1'b0, 32'h300, 8'd0, 2'b01, 4'b0010, -1, 0);
    do_read(1'b0, 32'h300, 8'd0, 2'b01, 0);
    check("strobe_model", model[32'h300 >> 2], 32'h1122FF44);

    $display("[TB] backpressure on B and R");
    wbuf[0] = 32'hA5A5_0001; wbuf[1] = 32'h5A5A_0002;
    do_write(1'b1, 32'h400, 8'd1, 2'b01, 4'hF, -1, 5);
    do_read(1'b1, 32'h400, 8'd1, 2'b01, 5);

    $display("[TB] early wlast");
    wbuf[0] = 32'h0BAD_0000; wbuf[1] = 32'h0BAD_0001;
    do_write(1'b0, 32'h500, 8'd1, 2'b01, 4'hF, 0, 0);
    do_read(1'b0, 32'h500, 8'd1, 2'b01, 0);

    $display("[TB] FIXED burst");
    wbuf[0] = 32'hAAAA_0000; wbuf[1] = 32'hBBBB_0000; wbuf[2] = 32'hCCCC_0000;
    do_write(1'b1, 32'h600, 8'd2, 2'b00, 4'hF, -1, 0);
    do_read(1'b1, 32'h600, 8'd1, 2'b00, 0);

    $display("[TB] address above backed RAM");
    wbuf[0] = 32'hCAFEF00D;
    do_write(1'b0, 32'h0, 8'd0, 2'b01, 4'hF, -1, 0);
    do_read(1'b0, 32'h0001_0000, 8'd0, 2'b01, 0);

    $display("[TB] reset during read burst");
    arid = 1'b1; araddr = 32'h200; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1; rready = 1'b1;
    t = 0;
    while (!arready && t < LIM) begin @(negedge clk); t++; end
    check("rst_ar_timeout", t >= LIM, 0);
    @(negedge clk);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < LIM) begin @(negedge clk); t++; end
    check("rst_r_timeout", t >= LIM, 0);
    check("rst_burst_beat0", rdata, model[32'h200 >> 2]);
    @(negedge clk);
    rready = 1'b0;
    @(negedge clk);
    check("rst_burst_beat1_valid", rvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_arready", arready, 0);
    check("mid_rst_awready", awready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_arready", arready, 1);
    check("after_rst_rvalid", rvalid, 0);
    do_read(1'b0, 32'h100, 8'd0, 2'b01, 0);

    check("sb_r_empty", r_q.size(), 0);
    check("sb_b_empty", b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
